// File: rtl/unidade_controle_seq.sv
// Control unit for the simple processor datapath: holds the instruction register
// and the T0-T3 step sequencer, decoding each instruction into datapath strobes.
module unidade_controle_seq #(
  parameter  int REG_ADDR_W = 3,
  parameter  int DATA_W     = 9,
  localparam int INSTR_W    = 3 + 2 * REG_ADDR_W,
  localparam int NUM_REGS   = 2 ** REG_ADDR_W
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Run,
  input  logic [DATA_W-1:0]   DIN,
  input  logic                Gnz,
  output logic [INSTR_W-1:0]  IR,
  output logic [1:0]          Tstep,
  output logic                IRin,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                Ain,
  output logic                Gin,
  output logic                Gout,
  output logic                DINout,
  output logic                AddSub,
  output logic [1:0]          ALUop,
  output logic                Done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  typedef enum logic [2:0] {
    OP_MV   = 3'd0,
    OP_MVI  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_MVNZ = 3'd5,
    OP_NOP6 = 3'd6,
    OP_NOP7 = 3'd7
  } opcode_t;

  step_t                step_q, step_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;

  opcode_t              opcode;
  logic [REG_ADDR_W-1:0] rx, ry;
  logic [NUM_REGS-1:0]  rx_oh, ry_oh;
  logic                 alu_instr;
  logic                 unused_din;

  assign opcode    = opcode_t'(ir_q[INSTR_W-1 -: 3]);
  assign rx        = ir_q[2*REG_ADDR_W-1 : REG_ADDR_W];
  assign ry        = ir_q[REG_ADDR_W-1 : 0];
  assign rx_oh     = NUM_REGS'(1) << rx;
  assign ry_oh     = NUM_REGS'(1) << ry;
  assign alu_instr = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);

  // Only the low INSTR_W bits of DIN reach the IR; the rest belong to the datapath.
  assign unused_din = ^DIN;

  always_comb begin
    step_d = step_q;
    ir_d   = ir_q;
    unique case (step_q)
      T0: begin
        if (Run) begin
          ir_d   = DIN[INSTR_W-1:0];
          step_d = T1;
        end
      end
      T1:      step_d = alu_instr ? T2 : T0;
      T2:      step_d = T3;
      T3:      step_d = T0;
      default: step_d = T0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

  // Strobes are gated by Resetn so a held reset silences the T0 fetch decode.
  always_comb begin
    IRin   = 1'b0;
    Rin    = '0;
    Rout   = '0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    Gout   = 1'b0;
    DINout = 1'b0;
    AddSub = 1'b0;
    ALUop  = 2'b00;
    Done   = 1'b0;
    if (Resetn) begin
      unique case (step_q)
        T0: begin
          IRin   = Run;
          DINout = Run;
        end
        T1: begin
          unique case (opcode)
            OP_MV: begin
              Rout = ry_oh;
              Rin  = rx_oh;
              Done = 1'b1;
            end
            OP_MVI: begin
              DINout = 1'b1;
              Rin    = rx_oh;
              Done   = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
              Rout = rx_oh;
              Ain  = 1'b1;
            end
            OP_MVNZ: begin
              Done = 1'b1;
              if (Gnz) begin
                Rout = ry_oh;
                Rin  = rx_oh;
              end
            end
            default: Done = 1'b1;
          endcase
        end
        T2: begin
          Rout   = ry_oh;
          Gin    = 1'b1;
          AddSub = (opcode == OP_SUB);
          ALUop  = (opcode == OP_AND) ? 2'b01 : 2'b00;
        end
        T3: begin
          Gout = 1'b1;
          Rin  = rx_oh;
          Done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign IR    = ir_q;
  assign Tstep = step_q;

endmodule

// File: tb/tb_unidade_controle_seq.sv
// Bench for unidade_controle_seq: directed vector table, multi-cycle sequences,
// a wide-field instance, and randomized traffic against a reference model.
module tb_unidade_controle_seq;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Run, Gnz;
  logic [8:0]  DIN;
  logic [8:0]  IR;
  logic [1:0]  Tstep, ALUop;
  logic        IRin, Ain, Gin, Gout, DINout, AddSub, Done;
  logic [7:0]  Rin, Rout;

  logic        run4, gnz4;
  logic [10:0] din4, ir4;
  logic [1:0]  tstep4, aluop4;
  logic        irin4, ain4, gin4, gout4, dinout4, addsub4, done4;
  logic [15:0] rin4, rout4;

  int tests = 0;
  int fails = 0;

  unidade_controle_seq #(.REG_ADDR_W(3), .DATA_W(9)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .Gnz(Gnz),
    .IR(IR), .Tstep(Tstep), .IRin(IRin), .Rin(Rin), .Rout(Rout),
    .Ain(Ain), .Gin(Gin), .Gout(Gout), .DINout(DINout), .AddSub(AddSub),
    .ALUop(ALUop), .Done(Done)
  );

  unidade_controle_seq #(.REG_ADDR_W(4), .DATA_W(11)) dut4 (
    .Clock(Clock), .Resetn(Resetn), .Run(run4), .DIN(din4), .Gnz(gnz4),
    .IR(ir4), .Tstep(tstep4), .IRin(irin4), .Rin(rin4), .Rout(rout4),
    .Ain(ain4), .Gin(gin4), .Gout(gout4), .DINout(dinout4), .AddSub(addsub4),
    .ALUop(aluop4), .Done(done4)
  );

  always #5 Clock = ~Clock;

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       run;
    logic [8:0] din;
    logic       gnz;
    logic [1:0] tstep;
    logic [7:0] rin;
    logic [7:0] rout;
    logic [8:0] flags; // {IRin,Ain,Gin,Gout,DINout,AddSub,ALUop[1:0],Done}
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic r, input logic [8:0] d, input logic g);
    @(negedge Clock);
    Run = r;
    DIN = d;
    Gnz = g;
    #1;
  endtask

  function automatic logic [8:0] flags3();
    return {IRin, Ain, Gin, Gout, DINout, AddSub, ALUop, Done};
  endfunction

  function automatic logic [35:0] all3();
    return {IR, Tstep, IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, ALUop, Done};
  endfunction

  // Reference: expected outputs from the instruction-set description.
  function automatic logic [35:0] model3(input int step, input logic [8:0] ir,
                                         input logic run, input logic gnz, input logic rstn);
    int op, rx, ry;
    logic irin, ain, gin, gout, dinout, addsub, done;
    logic [1:0] aluop;
    logic [7:0] rin, rout;
    op = int'(ir[8:6]);
    rx = int'(ir[5:3]);
    ry = int'(ir[2:0]);
    irin = 0; ain = 0; gin = 0; gout = 0; dinout = 0; addsub = 0; done = 0;
    aluop = 2'b00; rin = '0; rout = '0;
    if (!rstn) return '0;
    if (step == 0) begin
      irin = run;
      dinout = run;
    end else if (step == 1) begin
      if (op == 0) begin rout[ry] = 1; rin[rx] = 1; done = 1; end
      else if (op == 1) begin dinout = 1; rin[rx] = 1; done = 1; end
      else if (op >= 2 && op <= 4) begin rout[rx] = 1; ain = 1; end
      else if (op == 5) begin
        done = 1;
        if (gnz) begin rout[ry] = 1; rin[rx] = 1; end
      end else done = 1;
    end else if (step == 2) begin
      rout[ry] = 1; gin = 1;
      addsub = (op == 3);
      aluop = (op == 4) ? 2'b01 : 2'b00;
    end else begin
      gout = 1; rin[rx] = 1; done = 1;
    end
    return {ir, 2'(step), irin, rin, rout, ain, gin, gout, dinout, addsub, aluop, done};
  endfunction

  initial begin
    logic [7:0] done_map, irin_map;
    logic [8:0] seq_din[8];
    int         mstep, len;
    logic [8:0] mir;
    logic       r, g, rs;
    logic [8:0] d;

    vecs[0]  = '{1'b1, 9'b000_011_101, 1'b0, 2'd0, 8'h00, 8'h00, 9'h110};
    vecs[1]  = '{1'b0, 9'h000,         1'b0, 2'd1, 8'h08, 8'h20, 9'h001};
    vecs[2]  = '{1'b1, 9'b001_010_000, 1'b0, 2'd0, 8'h00, 8'h00, 9'h110};
    vecs[3]  = '{1'b0, 9'h005,         1'b0, 2'd1, 8'h04, 8'h00, 9'h011};
    vecs[4]  = '{1'b1, 9'b011_001_010, 1'b0, 2'd0, 8'h00, 8'h00, 9'h110};
    vecs[5]  = '{1'b0, 9'h000,         1'b0, 2'd1, 8'h00, 8'h02, 9'h080};
    vecs[6]  = '{1'b0, 9'h000,         1'b0, 2'd2, 8'h00, 8'h04, 9'h048};
    vecs[7]  = '{1'b0, 9'h000,         1'b0, 2'd3, 8'h02, 8'h00, 9'h021};
    vecs[8]  = '{1'b1, 9'b100_000_111, 1'b0, 2'd0, 8'h00, 8'h00, 9'h110};
    vecs[9]  = '{1'b0, 9'h000,         1'b0, 2'd1, 8'h00, 8'h01, 9'h080};
    vecs[10] = '{1'b0, 9'h000,         1'b0, 2'd2, 8'h00, 8'h80, 9'h042};
    vecs[11] = '{1'b0, 9'h000,         1'b0, 2'd3, 8'h01, 8'h00, 9'h021};
    vecs[12] = '{1'b1, 9'b101_110_001, 1'b0, 2'd0, 8'h00, 8'h00, 9'h110};
    vecs[13] = '{1'b0, 9'h000,         1'b0, 2'd1, 8'h00, 8'h00, 9'h001};
    vecs[14] = '{1'b1, 9'b101_110_001, 1'b1, 2'd0, 8'h00, 8'h00, 9'h110};
    vecs[15] = '{1'b0, 9'h000,         1'b1, 2'd1, 8'h40, 8'h02, 9'h001};
    vecs[16] = '{1'b1, 9'b111_101_010, 1'b0, 2'd0, 8'h00, 8'h00, 9'h110};
    vecs[17] = '{1'b0, 9'h000,         1'b0, 2'd1, 8'h00, 8'h00, 9'h001};
    vecs[18] = '{1'b0, 9'h1ff,         1'b0, 2'd0, 8'h00, 8'h00, 9'h000};

    Resetn = 1'b0; Run = 1'b1; DIN = 9'h0ff; Gnz = 1'b0;
    run4 = 1'b0; din4 = '0; gnz4 = 1'b0;
    #12;
    check("reset_all_zero", 64'(all3()), 64'd0);
    @(negedge Clock);
    Resetn = 1'b1; Run = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].run, vecs[i].din, vecs[i].gnz);
      check($sformatf("vec%0d", i), 64'({Tstep, Rin, Rout, flags3()}),
            64'({vecs[i].tstep, vecs[i].rin, vecs[i].rout, vecs[i].flags}));
    end

    // Run held high over mvi, add, mv: Done on cycles 2, 6 and 8.
    seq_din[0] = 9'b001_000_000; seq_din[1] = 9'h1ff;
    seq_din[2] = 9'b010_001_010; seq_din[3] = 9'h1c0;
    seq_din[4] = 9'h0c0;         seq_din[5] = 9'h040;
    seq_din[6] = 9'b000_011_100; seq_din[7] = 9'h1ff;
    done_map = '0; irin_map = '0;
    for (int n = 0; n < 8; n++) begin
      drive(1'b1, seq_din[n], 1'b0);
      done_map[n] = Done;
      irin_map[n] = IRin;
    end
    check("b2b_done_cycles", 64'(done_map), 64'h0A2);
    check("b2b_fetch_cycles", 64'(irin_map), 64'h045);
    drive(1'b0, 9'h000, 1'b0);
    check("b2b_ir_last", 64'({IR, Tstep}), 64'({9'b000_011_100, 2'd0}));

    // Reset asserted in T2 of an add.
    drive(1'b1, 9'b010_001_010, 1'b0);
    drive(1'b0, 9'h000, 1'b0);
    drive(1'b0, 9'h000, 1'b0);
    check("add_t2_before_reset", 64'({Tstep, Gin}), 64'({2'd2, 1'b1}));
    #2;
    Resetn = 1'b0; Run = 1'b1;
    #1;
    check("reset_mid_add", 64'(all3()), 64'd0);
    @(negedge Clock); #1;
    check("reset_held", 64'(all3()), 64'd0);
    @(negedge Clock);
    Resetn = 1'b1; Run = 1'b0;
    #1;
    check("reset_release_idle", 64'(all3()), 64'd0);
    drive(1'b0, 9'h1ff, 1'b1);
    check("idle_after_release", 64'(all3()), 64'd0);

    // Wide-field instance: add R9,R3.
    @(negedge Clock); run4 = 1'b1; din4 = 11'b010_1001_0011; #1;
    check("w4_t0_fetch", 64'({tstep4, irin4, dinout4}), 64'({2'd0, 1'b1, 1'b1}));
    @(negedge Clock); run4 = 1'b0; din4 = '0; #1;
    check("w4_t1", 64'({ir4, rout4, ain4, rin4}), 64'({11'b010_1001_0011, 16'h0200, 1'b1, 16'h0000}));
    @(negedge Clock); #1;
    check("w4_t2", 64'({rout4, gin4, addsub4, aluop4}), 64'({16'h0008, 1'b1, 1'b0, 2'b00}));
    @(negedge Clock); #1;
    check("w4_t3", 64'({rin4, gout4, done4, rout4}), 64'({16'h0200, 1'b1, 1'b1, 16'h0000}));
    @(negedge Clock); #1;
    check("w4_back_t0", 64'({tstep4, done4}), 64'({2'd0, 1'b0}));

    // Randomized traffic against the reference model (DUT is in T0 with IR=0).
    mstep = 0; mir = '0;
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 99) < 70);
      rs = ($urandom_range(0, 99) >= 2);
      d  = 9'($urandom);
      g  = 1'($urandom);
      @(negedge Clock);
      Resetn = rs; Run = r; DIN = d; Gnz = g;
      if (!rs) begin mstep = 0; mir = '0; end
      #1;
      check($sformatf("rand%0d", k), 64'(all3()), 64'(model3(mstep, mir, r, g, rs)));
      if (rs) begin
        if (mstep == 0) begin
          if (r) begin mir = d; mstep = 1; end
        end else begin
          len = (mir[8:6] >= 3'd2 && mir[8:6] <= 3'd4) ? 4 : 2;
          mstep = (mstep + 1) % len;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/unidade_controle_seq.md
# unidade_controle_seq

Parametrised, self-sequencing control unit for the simple processor datapath: owns the instruction register and the T0–T3 step state machine. It decodes opcode/Rx/Ry fields of configurable width into one-hot register enables and the bus, ALU and register-load strobes. It sits between the DIN/memory bus and the register file/ALU, and adds `and` and conditional move (`mvnz`) to the mv/mvi/add/sub set.

## Interface
Parameters:
- REG_ADDR_W, 3, width of the Rx and Ry fields; NUM_REGS = 2**REG_ADDR_W.
- DATA_W, 9, width of DIN; must be ≥ INSTR_W.
- INSTR_W (localparam), 3 + 2*REG_ADDR_W. Field layout:
  - opcode = IR[INSTR_W-1 -: 3]
  - Rx = IR[2*REG_ADDR_W-1 : REG_ADDR_W]
  - Ry = IR[REG_ADDR_W-1 : 0]

Ports:
- Clock  in  1  single system clock, rising edge.
- Resetn  in  1  reset, asynchronous assert, active low.
- Run  in  1  start request, sampled only in T0.
- DIN  in  DATA_W  data/instruction bus input; IR loads DIN[INSTR_W-1:0].
- Gnz  in  1  G register non-zero flag from the datapath.
- IR  out  INSTR_W  instruction register contents.
- Tstep  out  2  current step: 0=T0, 1=T1, 2=T2, 3=T3.
- IRin  out  1  IR load strobe (mirrors the internal load).
- Rin  out  NUM_REGS  one-hot register write enable.
- Rout  out  NUM_REGS  one-hot register bus drive.
- Ain, Gin, Gout, DINout  out  1  datapath strobes.
- AddSub  out  1  1 = subtract.
- ALUop  out  2  00 = add/sub, 01 = and.
- Done  out  1  final step of the instruction.

## Operation
- State: Tstep register (T0..T3) and IR register; all outputs are combinational from Tstep, IR, Run and Gnz.
- Every strobe defaults to 0 in every step unless listed below.
- T0:
  - Run=1: IRin=1, DINout=1; at the clock edge IR <= DIN[INSTR_W-1:0] and go to T1.
  - Run=0: all strobes 0, stay in T0.
- Opcode 000, mv: T1: Rout[Ry]=1, Rin[Rx]=1, Done=1, then T0.
- Opcode 001, mvi: T1: DINout=1, Rin[Rx]=1, Done=1, then T0. The immediate word is presented on DIN during T1.
- Opcodes 010 add, 011 sub, 100 and:
  - T1: Rout[Rx]=1, Ain=1, then T2.
  - T2: Rout[Ry]=1, Gin=1; AddSub=1 only for sub; ALUop=01 only for and, else 00; then T3.
  - T3: Gout=1, Rin[Rx]=1, Done=1, then T0.
- Opcode 101, mvnz: T1: Done=1. If Gnz=1, also Rout[Ry]=1 and Rin[Rx]=1; if Gnz=0, no register write. Then T0.
- Opcodes 110, 111: no-op. T1: Done=1 only, then T0.
- Rx == Ry is legal: mv is a self-copy; add R,R doubles the register.
- Rin/Rout always carry at most one set bit.

## Timing
- Reset (Resetn=0, asynchronous): Tstep=T0 and IR=0 immediately.
  - While in reset, every output is 0 regardless of Run.
  - Asserting reset mid-instruction aborts it with no further strobes.
- First T0 after reset release follows the normal Run rules.
- Latency from the T0 fetch edge to Done:
  - mv, mvi, mvnz, no-op: Done in T1 (2 cycles per instruction including fetch).
  - add, sub, and: Done in T3 (4 cycles).
- Done is high for exactly one cycle; the next edge returns to T0.
- Back-to-back: with Run held high, the next fetch occurs in the cycle right after Done.
- Run is ignored in T1–T3; dropping Run mid-instruction does not stop it.
- IR changes only on a T0 edge with Run=1; it stays stable through T1–T3.
- Gnz is sampled combinationally in T1 of mvnz only.

## Test plan
- Reset: drive Resetn=0 in T2 of an add -> Tstep=0, IR=0, all strobes 0 within the same cycle; after release with Run=0, stays T0 with no strobes.
- mv and mvi, REG_ADDR_W=3:
  - DIN=9'b000_011_101 -> T1: Rin=8'h08, Rout=8'h20, Done=1.
  - Then DIN=9'b001_010_000 followed by immediate 9'h05 -> T1: DINout=1, Rin=8'h04, Done=1.
- sub R1,R2 (9'b011_001_010):
  - T1: Rout=8'h02, Ain=1.
  - T2: Rout=8'h04, Gin=1, AddSub=1, ALUop=00.
  - T3: Gout=1, Rin=8'h02, Done=1. Four-cycle period.
- and and mvnz:
  - 9'b100_000_111 -> T2: ALUop=01, AddSub=0.
  - 9'b101_110_001 with Gnz=0 -> Done only, Rin=0.
  - Same with Gnz=1 -> Rin=8'h40, Rout=8'h02.
- Run held high over mvi, add, mv -> Done on cycles 2, 6 and 8 counted from the first fetch, no idle gaps. Opcode 111 -> Done at T1, no other strobes.
- REG_ADDR_W=4, DATA_W=11:
  - add R9,R3 (11'b010_1001_0011) -> T1: Rout=16'h0200.
  - T2: Rout=16'h0008.
  - T3: Rin=16'h0200.
